mem_access_stage: RTL and testbench

// - MEM stage between the EX/MEM and MEM/WB registers. Drives a data memory over a req/ack handshake.
// - Handles byte/half/word alignment for stores and sign/zero extension for loads.
// - Stalls the pipeline while an access is outstanding. Flags misaligned accesses and memory timeouts.

---
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data memory, aligns stores, extends loads,
// stalls the pipeline while an access is outstanding and flags misalign/timeout.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_write_reg,
  input  logic [1:0]  i_WB_control,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  output logic [4:0]  o_write_reg,
  output logic [31:0] o_write_data,
  output logic [31:0] o_result,
  output logic [1:0]  o_WB_control,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        ld_data_q;
  logic               squash_q;
  logic [1:0]         lo_q;
  logic [1:0]         size_q;
  logic               uns_q;

  logic               mem_op;
  logic               misalign;
  logic               start;
  logic               ack_done;
  logic               tmo;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic [31:0]        ext_c;

  assign mem_op   = i_valid & (i_mem_read | i_mem_write);
  assign misalign = ((i_size == 2'b01) & i_addr[0]) | (i_size[1] & (|i_addr[1:0]));

  // Store lane encoding from the live EX/MEM inputs
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = i_store_data;
    case (i_size)
      2'b00: begin
        be_c    = 4'b0001 << i_addr[1:0];
        wdata_c = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{i_store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = i_store_data;
      end
    endcase
  end

  // Load lane select and extension, using the attributes captured at request time
  always_comb begin
    byte_c = i_mem_rdata[7:0];
    case (lo_q)
      2'b00:   byte_c = i_mem_rdata[7:0];
      2'b01:   byte_c = i_mem_rdata[15:8];
      2'b10:   byte_c = i_mem_rdata[23:16];
      default: byte_c = i_mem_rdata[31:24];
    endcase
    half_c = lo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (size_q)
      2'b00:   ext_c = uns_q ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   ext_c = uns_q ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: ext_c = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    ack_done     = 1'b0;
    tmo          = 1'b0;
    o_stall      = 1'b0;
    o_misalign   = 1'b0;
    o_bus_err    = 1'b0;
    o_write_reg  = i_write_reg;
    o_result     = i_addr;
    o_WB_control = i_WB_control;
    o_write_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (misalign) begin
            o_misalign   = 1'b1;
            o_WB_control = 2'b00;
          end else begin
            o_stall = 1'b1;
            start   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        o_stall = 1'b1;
        if (i_mem_ack) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo       = 1'b1;
          o_bus_err = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        o_write_data = ld_data_q;
        if (squash_q) o_WB_control = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_rst) begin
      o_stall      = 1'b0;
      o_misalign   = 1'b0;
      o_bus_err    = 1'b0;
      o_write_reg  = 5'h0;
      o_result     = 32'h0;
      o_WB_control = 2'b00;
      o_write_data = 32'h0;
    end
  end

  // Memory interface and holding registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_be    <= 4'h0;
      o_mem_wdata <= 32'h0;
      cnt_q       <= '0;
      ld_data_q   <= 32'h0;
      squash_q    <= 1'b0;
      lo_q        <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else if (start) begin
      o_mem_req   <= 1'b1;
      o_mem_we    <= i_mem_write;
      o_mem_addr  <= {i_addr[31:2], 2'b00};
      o_mem_be    <= be_c;
      o_mem_wdata <= i_mem_write ? wdata_c : 32'h0;
      cnt_q       <= '0;
      ld_data_q   <= 32'h0;
      squash_q    <= 1'b0;
      lo_q        <= i_addr[1:0];
      size_q      <= i_size;
      uns_q       <= i_unsigned;
    end else if (ack_done) begin
      o_mem_req <= 1'b0;
      ld_data_q <= o_mem_we ? 32'h0 : ext_c;
    end else if (tmo) begin
      o_mem_req <= 1'b0;
      ld_data_q <= 32'h0;
      squash_q  <= 1'b1;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single accesses plus
// hand sequences for ack delay, timeout, stray ack and reset mid-access.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        valid, mem_read, mem_write, uns, mem_ack;
  logic [1:0]  size, wb_in;
  logic [31:0] addr, sdata, rdata;
  logic [4:0]  wreg;
  logic        mem_req, mem_we, stall, mis, bus_err;
  logic [31:0] mem_addr, mem_wdata, write_data, result;
  logic [3:0]  mem_be;
  logic [4:0]  write_reg;
  logic [1:0]  wb_out;

  int n_chk;
  int n_fail;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_size(size), .i_unsigned(uns), .i_addr(addr),
    .i_store_data(sdata), .i_write_reg(wreg), .i_WB_control(wb_in),
    .i_mem_ack(mem_ack), .i_mem_rdata(rdata), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .o_write_reg(write_reg), .o_write_data(write_data),
    .o_result(result), .o_WB_control(wb_out), .o_stall(stall),
    .o_misalign(mis), .o_bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, sdata, rdata;
    logic [4:0]  rg;
    logic [1:0]  wb;
    logic        e_stall, e_mis;
    logic [1:0]  e_wb;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_wdo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic [4:0] rg, input logic [1:0] wb);
    valid = v; mem_read = r; mem_write = w; size = sz; uns = u;
    addr = a; sdata = d; rdata = rd; wreg = rg; wb_in = wb;
  endtask

  // Runs one access already driven at posedge+1; ack_at = BUSY cycle number of the ack, 0 = never
  task automatic mem_seq(input int ack_at, output int stall_n, output int err_n,
                         output logic [31:0] wd, output logic [1:0] wb_done);
    int  c;
    logic fin;
    stall_n = 0; err_n = 0; wd = 32'hx; wb_done = 2'bx; c = 0; fin = 1'b0;
    while (!fin && c < 20) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (bus_err) err_n++;
      if (!stall && c > 0) begin
        wd = write_data;
        wb_done = wb_out;
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        mem_ack = (ack_at != 0) && (c + 1 == ack_at);
        c++;
      end
    end
    if (!fin) chk("seq_bound", 32'(c), 32'(0));
    @(posedge clk); #1;
    valid = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    int          sn, en;
    logic [31:0] wd;
    logic [1:0]  wbd;

    n_chk = 0; n_fail = 0;
    //              v     rd    wr    size   uns   addr          sdata          rdata          rg     wb     stl   mis   e_wb   e_be     e_wdata        e_wdo
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0,         32'h0,         5'd5,  2'b10, 1'b0, 1'b0, 2'b10, 4'b0000, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         5'd7,  2'b11, 1'b0, 1'b0, 2'b11, 4'b0000, 32'h0,         32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         5'd3,  2'b01, 1'b0, 1'b1, 2'b00, 4'b0000, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,         32'h0,         5'd4,  2'b11, 1'b0, 1'b1, 2'b00, 4'b0000, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0203, 32'h55,        32'h0,         5'd6,  2'b10, 1'b0, 1'b1, 2'b00, 4'b0000, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_00AB, 32'h0,         5'd9,  2'b10, 1'b1, 1'b0, 2'b10, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h1234_CAFE, 32'h0,         5'd10, 2'b10, 1'b1, 1'b0, 2'b10, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0,         5'd11, 2'b01, 1'b1, 1'b0, 2'b01, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 5'd12, 2'b11, 1'b1, 1'b0, 2'b11, 4'b1100, 32'h0,         32'h0000_BEEF};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,         32'h1234_8001, 5'd13, 2'b11, 1'b1, 1'b0, 2'b11, 4'b0011, 32'h0,         32'hFFFF_8001};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_A500, 5'd14, 2'b11, 1'b1, 1'b0, 2'b11, 4'b0010, 32'h0,         32'h0000_00A5};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0,         32'h007F_0000, 5'd15, 2'b11, 1'b1, 1'b0, 2'b11, 4'b0100, 32'h0,         32'h0000_007F};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'hFFFF_FFFF, 5'd16, 2'b10, 1'b1, 1'b0, 2'b10, 4'b1111, 32'h1122_3344, 32'h0};

    // Reset: combinational outputs forced low even with live inputs
    rst = 1'b1; mem_ack = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 2'b11);
    #12;
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_write_reg", 32'(write_reg), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_wb", 32'(wb_out), 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr,
            vecs[i].sdata, vecs[i].rdata, vecs[i].rg, vecs[i].wb);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_mis", i), 32'(mis), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d_wb", i), 32'(wb_out), 32'(vecs[i].e_wb));
      chk($sformatf("v%0d_reg", i), 32'(write_reg), 32'(vecs[i].rg));
      chk($sformatf("v%0d_result", i), result, vecs[i].addr);
      chk($sformatf("v%0d_wdata_idle", i), write_data, 32'h0);
      chk($sformatf("v%0d_req_idle", i), 32'(mem_req), 32'h0);
      if (vecs[i].e_stall) begin
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_req", i), 32'(mem_req), 32'h1);
        chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].wr));
        chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(vecs[i].e_be));
        chk($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_stall_busy", i), 32'(stall), 32'h1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_stall_done", i), 32'(stall), 32'h0);
        chk($sformatf("v%0d_req_done", i), 32'(mem_req), 32'h0);
        chk($sformatf("v%0d_wdo", i), write_data, vecs[i].e_wdo);
        chk($sformatf("v%0d_wb_done", i), 32'(wb_out), 32'(vecs[i].wb));
      end else begin
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d_no_req", i), 32'(mem_req), 32'h0);
      end
      @(posedge clk); #1;
      valid = 1'b0;
    end

    // lb with ack in the second BUSY cycle
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 5'd20, 2'b01);
    mem_seq(2, sn, en, wd, wbd);
    chk("lb_stall_cycles", 32'(sn), 32'd3);
    chk("lb_data", wd, 32'hFFFF_FF80);
    chk("lb_wb", 32'(wbd), 32'h1);

    // lhu with ack in the first BUSY cycle
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hBEEF_0000, 5'd21, 2'b11);
    mem_seq(1, sn, en, wd, wbd);
    chk("lhu_stall_cycles", 32'(sn), 32'd2);
    chk("lhu_data", wd, 32'h0000_BEEF);

    // No ack: timeout after 4 BUSY cycles, WB squashed
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h1357_9BDF, 5'd22, 2'b11);
    mem_seq(0, sn, en, wd, wbd);
    chk("tmo_stall_cycles", 32'(sn), 32'd5);
    chk("tmo_err_pulses", 32'(en), 32'd1);
    chk("tmo_data", wd, 32'h0);
    chk("tmo_wb", 32'(wbd), 32'h0);
    chk("tmo_req", 32'(mem_req), 32'h0);

    // Following access after a timeout completes normally and is not squashed
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h2468_ACE0, 5'd23, 2'b10);
    mem_seq(3, sn, en, wd, wbd);
    chk("post_tmo_stall", 32'(sn), 32'd4);
    chk("post_tmo_err", 32'(en), 32'd0);
    chk("post_tmo_data", wd, 32'h2468_ACE0);
    chk("post_tmo_wb", 32'(wbd), 32'h2);

    // Stray ack in IDLE is ignored
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd0, 2'b00);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_req", 32'(mem_req), 32'h0);
    chk("stray_stall", 32'(stall), 32'h0);
    chk("stray_data", write_data, 32'h0);

    // Reset asserted mid-BUSY aborts at once
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 5'd24, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_req_before", 32'(mem_req), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_req", 32'(mem_req), 32'h0);
    chk("abort_stall", 32'(stall), 32'h0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hBEEF_0000, 5'd25, 2'b11);
    mem_seq(1, sn, en, wd, wbd);
    chk("post_rst_stall", 32'(sn), 32'd2);
    chk("post_rst_data", wd, 32'h0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
